display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Scan scheduler for the six-digit 7-segment BCD display mux.
//  - Generates the 3-bit digit-select sequence at a fixed per-digit refresh rate.
//  - Holds a shadow copy of the six BCD digits, reloaded only at frame boundaries
//    through a req/ack handshake, so clock/stopwatch updates never tear a frame.
//  - Drives a blank flag for the downstream anode/cathode driver.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency
//  DIGIT_HZ    1_000        per-digit dwell rate; PRESCALE = CLK_HZ/DIGIT_HZ, must be >= 2
//  NUM_DIGITS  6            digits scanned, 1..6; select codes >= NUM_DIGITS are never emitted
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   1 = scan running; 0 = hold and blank
//  digits_in    in   24  BCD digits; [3:0] = digit1 ... [23:20] = digit6
//  load_req     in   1   request to copy digits_in into the shadow register
//  load_ack     out  1   one-cycle pulse: shadow loaded; requester may drop load_req
//  digit_sel    out  3   current digit index, 0..NUM_DIGITS-1, to the BCD mux select
//  digit_data   out  4   shadow BCD value for digit_sel
//  blank        out  1   1 = all anodes off
//  scan_tick    out  1   one-cycle pulse on each digit_sel change
//  frame_done   out  1   one-cycle pulse when digit_sel wraps to 0
// BEHAVIOUR
//  - Reset: prescaler=0, digit_sel=0, digit_data=0, shadow=0, blank=1,
//    load_ack=0, scan_tick=0, frame_done=0.
//  - Prescaler counts 0..PRESCALE-1 while enable=1. At terminal count it wraps to 0.
//    On that same edge, digit_sel advances (NUM_DIGITS-1 -> 0) and scan_tick=1.
//    All outputs are registered; the index period is exactly PRESCALE cycles.
//  - digit_data is registered with digit_sel on the same edge, so it always matches
//    the displayed index with zero skew.
//  - frame_done=1 on the edge where digit_sel becomes 0 by wrap. It does not assert
//    on reset exit.
//  - Load handshake:
//    - load_req is sampled only at the wrap edge. If high, shadow <= digits_in,
//      load_ack=1 for that one cycle, and digit_data for index 0 takes digits_in[3:0]
//      directly.
//    - The requester holds load_req and digits_in stable until load_ack.
//    - A req dropped before ack is ignored; no load occurs.
//    - A req still high the cycle after ack is treated as a new request for the next frame.
//  - enable=0: prescaler and digit_sel reset to 0 synchronously. blank=1, no ticks,
//    no loads, shadow retained.
//    On enable rising, blank=0 on the next edge and scanning restarts at digit 0 with
//    a full dwell.
//  - blank=0 whenever enable=1, except as modified by the blink feature below.
//  - Reset asserted mid-frame returns all state to reset values immediately. A pending
//    load is lost and is not acked.
// CONFIGURATION
//  - DISPLAY_BLINK_EN defined:
//    - Adds input blink_mask[5:0], bit i controlling digit i.
//    - Adds a blink counter that toggles blink_phase every CLK_HZ/4 cycles (2 Hz
//      square wave); reset phase = on.
//    - blank=1 while phase = off and blink_mask[digit_sel]=1. Used for digit editing
//      during time-set.
//  - Not defined: blink_mask port and blink counter are absent; blank depends on
//    enable only.
// STRUCTURE
//  - Shared package display_pkg holds:
//    - DIGIT_W=4, SEL_W=3, MAX_DIGITS=6
//    - the BLANK_SEL code 3'b111 for the mux "all anodes off" select
//    - a bcd_digit_t typedef
//  - One sub-module, scan_prescaler: parameterised terminal-count counter with
//    synchronous clear, producing a one-cycle tick. Instantiated twice: once for the
//    digit dwell, once for the blink phase under DISPLAY_BLINK_EN.
// TESTING (CLK_HZ=40, DIGIT_HZ=10 -> PRESCALE=4; NUM_DIGITS=6)
//  1. Reset release with enable=1 -> blank=1 for the reset cycle, then digit_sel
//     0,1,2,3,4,5,0 with 4 cycles each. scan_tick every 4th cycle. frame_done only
//     on the 5->0 edge.
//  2. digits_in=24'h654321, load_req raised while digit_sel=2 -> load_ack exactly
//     at the next wrap. digit_data then reads 1,2,3,4,5,6 over the following frame.
//  3. load_req pulsed high for 2 cycles mid-frame, then dropped -> no load_ack;
//     shadow unchanged.
//  4. enable=0 while digit_sel=3 -> next edge: digit_sel=0, blank=1, no ticks.
//     Re-enable -> digit 0 dwells a full 4 cycles.
//  5. rst_n asserted during a pending load_req at digit_sel=5 -> all outputs at reset
//     values asynchronously; shadow=0; no ack after release until the next wrap.
//  6. With DISPLAY_BLINK_EN and blink_mask=6'b000011 -> digits 0-1 blank during the
//     off phase, digits 2-5 never blank. Phase toggles every 10 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared widths, codes and types for the six-digit 7-segment scan controller.
package display_pkg;

   localparam int DIGIT_W    = 4;
   localparam int SEL_W      = 3;
   localparam int MAX_DIGITS = 6;

   // Mux select that turns every anode off.
   localparam logic [SEL_W-1:0] BLANK_SEL = 3'b111;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

endpackage

// File: rtl/scan_prescaler.sv
// Terminal-count counter 0..PRESCALE-1 with synchronous clear.
// Emits a one-cycle tick in the cycle the count sits at terminal count.
module scan_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] TC = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_tc;

   assign at_tc = (cnt_q == TC);
   assign tick  = en & ~clr & at_tc;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_tc ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit 7-segment scan scheduler with frame-aligned shadow reload.
// Optional per-digit blinking is built in when DISPLAY_BLINK_EN is defined.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int DIGIT_HZ   = 1_000,
   parameter int NUM_DIGITS = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [MAX_DIGITS*DIGIT_W-1:0] digits_in,
   input  logic                          load_req,
`ifdef DISPLAY_BLINK_EN
   input  logic [MAX_DIGITS-1:0]         blink_mask,
`endif
   output logic                          load_ack,
   output logic [SEL_W-1:0]              digit_sel,
   output logic [DIGIT_W-1:0]            digit_data,
   output logic                          blank,
   output logic                          scan_tick,
   output logic                          frame_done
);

   localparam int PRESCALE = CLK_HZ / DIGIT_HZ;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

   logic                          run_q, run_d;
   logic [SEL_W-1:0]              sel_q, sel_d;
   bcd_digit_t                    data_q, data_d;
   logic [MAX_DIGITS*DIGIT_W-1:0] shadow_q, shadow_d;
   logic                          blank_q, blank_d;
   logic                          tick_q, tick_d;
   logic                          frame_q, frame_d;
   logic                          ack_q, ack_d;

   logic dwell_tick, dwell_clr, wrap, load;

   // The first enabled cycle only unblanks; the dwell count starts after it,
   // so digit 0 is visible for a full PRESCALE cycles after reset or re-enable.
   assign dwell_clr = ~enable | ~run_q;
   assign wrap      = dwell_tick & (sel_q == LAST_SEL);
   assign load      = wrap & load_req;

   scan_prescaler #(.PRESCALE(PRESCALE)) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enable),
      .clr   (dwell_clr),
      .tick  (dwell_tick)
   );

`ifdef DISPLAY_BLINK_EN
   localparam int BLINK_PRESCALE = CLK_HZ / 4;

   logic                 blink_tick;
   logic                 phase_q, phase_d;
   logic [2**SEL_W-1:0]  mask_ext;

   assign mask_ext = {{(2**SEL_W-MAX_DIGITS){1'b0}}, blink_mask};

   scan_prescaler #(.PRESCALE(BLINK_PRESCALE)) u_blink (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .clr   (1'b0),
      .tick  (blink_tick)
   );

   always_comb begin
      phase_d = phase_q;
      if (blink_tick) begin
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b1;
      end else begin
         phase_q <= phase_d;
      end
   end
`endif

   always_comb begin
      run_d    = enable;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      ack_d    = 1'b0;
      tick_d   = dwell_tick;
      frame_d  = wrap;

      if (!enable) begin
         sel_d = '0;
      end else if (dwell_tick) begin
         sel_d = wrap ? '0 : sel_q + 1'b1;
      end

      if (load) begin
         shadow_d = digits_in;
         ack_d    = 1'b1;
      end

      // Data comes from the next shadow, so a load shows on digit 0 at once.
      data_d = shadow_d[int'(sel_d)*DIGIT_W +: DIGIT_W];

`ifdef DISPLAY_BLINK_EN
      blank_d = ~enable | (~phase_d & mask_ext[sel_d]);
`else
      blank_d = ~enable;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         sel_q    <= '0;
         data_q   <= '0;
         shadow_q <= '0;
         blank_q  <= 1'b1;
         tick_q   <= 1'b0;
         frame_q  <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         run_q    <= run_d;
         sel_q    <= sel_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
         blank_q  <= blank_d;
         tick_q   <= tick_d;
         frame_q  <= frame_d;
         ack_q    <= ack_d;
      end
   end

   assign load_ack   = ack_q;
   assign digit_sel  = sel_q;
   assign digit_data = data_q;
   assign blank      = blank_q;
   assign scan_tick  = tick_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl at PRESCALE=4, six digits.
// Blink checks are built in when DISPLAY_BLINK_EN is defined.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        load_req = 1'b0;
   logic [23:0] digits_in = '0;
`ifdef DISPLAY_BLINK_EN
   logic [5:0]  blink_mask = '0;
`endif
   logic        load_ack;
   logic [2:0]  digit_sel;
   logic [3:0]  digit_data;
   logic        blank;
   logic        scan_tick;
   logic        frame_done;

   typedef struct {
      int sel;
      int data;
      int frame;
      int ack;
      int gap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   display_scan_ctrl #(
      .CLK_HZ     (40),
      .DIGIT_HZ   (10),
      .NUM_DIGITS (6)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .digits_in  (digits_in),
      .load_req   (load_req),
`ifdef DISPLAY_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .load_ack   (load_ack),
      .digit_sel  (digit_sel),
      .digit_data (digit_data),
      .blank      (blank),
      .scan_tick  (scan_tick),
      .frame_done (frame_done)
   );

   task automatic chk_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic sb_push(input int sel, input int data, input int frame,
                          input int ack, input int gap);
      exp_t e;
      e.sel = sel; e.data = data; e.frame = frame; e.ack = ack; e.gap = gap;
      sb.push_back(e);
   endtask

   // Wait for the next scan_tick and compare it with the oldest expectation.
   task automatic expect_tick();
      int   n = 0;
      bit   seen = 1'b0;
      exp_t e;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (scan_tick) seen = 1'b1;
         else chk_eq("no_pulse_between_ticks", int'({frame_done, load_ack}), 0);
      end
      chk_eq("tick_seen", int'(seen), 1);
      if (!seen) return;
      if (sb.size() == 0) begin
         chk_eq("sb_has_entry", 0, 1);
         return;
      end
      e = sb.pop_front();
      chk_eq("tick_gap", cyc - last_cyc, e.gap);
      chk_eq("digit_sel", int'(digit_sel), e.sel);
      chk_eq("digit_data", int'(digit_data), e.data);
      chk_eq("frame_done", int'(frame_done), e.frame);
      chk_eq("load_ack", int'(load_ack), e.ack);
      chk_eq("blank_run", int'(blank), 0);
      last_cyc = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset values, then one full frame of zeros
      rst_n  = 1'b0;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      chk_eq("rst_sel", int'(digit_sel), 0);
      chk_eq("rst_data", int'(digit_data), 0);
      chk_eq("rst_blank", int'(blank), 1);
      chk_eq("rst_ack", int'(load_ack), 0);
      chk_eq("rst_tick", int'(scan_tick), 0);
      chk_eq("rst_frame", int'(frame_done), 0);
      rst_n    = 1'b1;
      last_cyc = cyc;
      sb_push(1, 0, 0, 0, 5);
      for (int s = 2; s <= 5; s++) sb_push(s, 0, 0, 0, 4);
      sb_push(0, 0, 1, 0, 4);
      @(negedge clk);
      chk_eq("unblank_after_reset", int'(blank), 0);
      chk_eq("sel0_after_reset", int'(digit_sel), 0);
      chk_eq("no_frame_on_reset_exit", int'(frame_done), 0);
      repeat (6) expect_tick();

      // 2: load requested at digit 2, acked at the wrap
      sb_push(1, 0, 0, 0, 4);
      sb_push(2, 0, 0, 0, 4);
      repeat (2) expect_tick();
      digits_in = 24'h654321;
      load_req  = 1'b1;
      for (int s = 3; s <= 5; s++) sb_push(s, 0, 0, 0, 4);
      sb_push(0, 1, 1, 1, 4);
      repeat (4) expect_tick();
      load_req = 1'b0;
      for (int s = 1; s <= 5; s++) sb_push(s, s + 1, 0, 0, 4);
      sb_push(0, 1, 1, 0, 4);
      repeat (6) expect_tick();

      // 3: short request dropped before the wrap is ignored
      digits_in = 24'h987987;
      sb_push(1, 2, 0, 0, 4);
      expect_tick();
      load_req = 1'b1;
      repeat (2) @(negedge clk);
      load_req = 1'b0;
      for (int s = 2; s <= 5; s++) sb_push(s, s + 1, 0, 0, 4);
      sb_push(0, 1, 1, 0, 4);
      repeat (5) expect_tick();

      // 4: disable at digit 3, then re-enable with a full dwell
      for (int s = 1; s <= 3; s++) sb_push(s, s + 1, 0, 0, 4);
      repeat (3) expect_tick();
      enable = 1'b0;
      @(negedge clk);
      chk_eq("dis_sel", int'(digit_sel), 0);
      chk_eq("dis_data", int'(digit_data), 1);
      for (int i = 0; i < 6; i++) begin
         chk_eq("dis_blank", int'(blank), 1);
         chk_eq("dis_tick", int'(scan_tick), 0);
         @(negedge clk);
      end
      enable   = 1'b1;
      last_cyc = cyc;
      @(negedge clk);
      chk_eq("reen_blank", int'(blank), 0);
      chk_eq("reen_sel", int'(digit_sel), 0);
      sb_push(1, 2, 0, 0, 5);
      expect_tick();

      // 5: reset during a pending load at digit 5
      for (int s = 2; s <= 5; s++) sb_push(s, s + 1, 0, 0, 4);
      repeat (4) expect_tick();
      digits_in = 24'h111111;
      load_req  = 1'b1;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("async_rst_sel", int'(digit_sel), 0);
      chk_eq("async_rst_data", int'(digit_data), 0);
      chk_eq("async_rst_blank", int'(blank), 1);
      chk_eq("async_rst_ack", int'(load_ack), 0);
      chk_eq("async_rst_tick", int'(scan_tick), 0);
      chk_eq("async_rst_frame", int'(frame_done), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_cyc = cyc;
      sb_push(1, 0, 0, 0, 5);
      for (int s = 2; s <= 5; s++) sb_push(s, 0, 0, 0, 4);
      sb_push(0, 1, 1, 1, 4);
      repeat (6) expect_tick();
      load_req = 1'b0;
      sb_push(1, 1, 0, 0, 4);
      expect_tick();
      chk_eq("sb_left", sb.size(), 0);

`ifdef DISPLAY_BLINK_EN
      // 6: digits 0-1 blink, 2-5 stay lit; phase flips every 10 cycles
      begin
         int rel, k, esel, eblank;
         @(negedge clk);
         rst_n      = 1'b0;
         blink_mask = 6'b000011;
         @(negedge clk);
         rst_n = 1'b1;
         rel   = cyc;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            k      = cyc - rel;
            esel   = (k < 5) ? 0 : (((k - 5) / 4) + 1) % 6;
            eblank = (((k / 10) % 2) == 1 && esel < 2) ? 1 : 0;
            chk_eq("blink_sel", int'(digit_sel), esel);
            chk_eq("blink_blank", int'(blank), eblank);
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
